// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first
//
// Computes oDIFF = iA - iB (mod 2^WIDTH) one bit per clock using a single
// borrow flop. A start/done handshake is used, and the result is held until
// the next operation completes.
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN adds oOVF (signed overflow).
//
// Ports:
//   iCLK     in   1      system clock, rising edge
//   iRST     in   1      asynchronous active-high reset
//   iSTART   in   1      request, sampled only in IDLE
//   iA       in   WIDTH  minuend, captured on accepted iSTART
//   iB       in   WIDTH  subtrahend, captured on accepted iSTART
//   oBUSY    out  1      high in SHIFT and DONE
//   oDONE    out  1      one-cycle pulse when the result becomes valid
//   oDIFF    out  WIDTH  iA - iB modulo 2^WIDTH
//   oBORROW  out  1      final borrow out (unsigned iA < iB)
//   oZERO    out  1      oDIFF == 0
//   oOVF     out  1      signed overflow (only with SERIAL_SUBTRACTOR_OVERFLOW_EN)

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iSTART,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oBUSY,
   output logic             oDONE,
   output logic [WIDTH-1:0] oDIFF,
   output logic             oBORROW,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   output logic             oZERO,
   output logic             oOVF
`else
   output logic             oZERO
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;
   state_t nextState;

   logic [WIDTH-1:0] aSr;
   logic [WIDTH-1:0] bSr;
   logic [WIDTH-1:0] resSr;
   logic             borrow;
   logic [CW-1:0]    cnt;

   logic             aBit;
   logic             bBit;
   logic             dBit;
   logic             brNext;
   logic [WIDTH-1:0] resNext;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   logic aMsb;
   logic bMsb;
`endif

   // Single full-subtractor cell; the borrow flop stands in for the carry chain.
   always_comb begin
      aBit    = aSr[0];
      bBit    = bSr[0];
      dBit    = aBit ^ bBit ^ borrow;
      brNext  = (~aBit & bBit) | (~(aBit ^ bBit) & borrow);
      // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
      resNext = {dBit, resSr[WIDTH-1:1]};
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      oBUSY     = 1'b0;
      oDONE     = 1'b0;
      case (state)
         IDLE: begin
            if (iSTART) begin
               nextState = SHIFT;
            end
         end
         SHIFT: begin
            oBUSY = 1'b1;
            if (cnt == LAST) begin
               nextState = DONE;
            end
         end
         DONE: begin
            oBUSY     = 1'b1;
            oDONE     = 1'b1;
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         aSr     <= '0;
         bSr     <= '0;
         resSr   <= '0;
         borrow  <= 1'b0;
         cnt     <= '0;
         oDIFF   <= '0;
         oBORROW <= 1'b0;
         oZERO   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
         aMsb    <= 1'b0;
         bMsb    <= 1'b0;
         oOVF    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (iSTART) begin
                  aSr    <= iA;
                  bSr    <= iB;
                  resSr  <= '0;
                  borrow <= 1'b0;
                  cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                  aMsb   <= iA[WIDTH-1];
                  bMsb   <= iB[WIDTH-1];
`endif
               end
            end
            SHIFT: begin
               aSr    <= aSr >> 1;
               bSr    <= bSr >> 1;
               resSr  <= resNext;
               borrow <= brNext;
               if (cnt == LAST) begin
                  // Visible outputs only change here, so no partial result leaks out.
                  oDIFF   <= resNext;
                  oBORROW <= brNext;
                  oZERO   <= (resNext == '0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                  oOVF    <= (aMsb != bMsb) && (resNext[WIDTH-1] != aMsb);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor

module tb_serial_subtractor;

   localparam int W = 8;

   logic         iCLK = 1'b0;
   logic         iRST;
   logic         iSTART;
   logic [W-1:0] iA;
   logic [W-1:0] iB;
   logic         oBUSY;
   logic         oDONE;
   logic [W-1:0] oDIFF;
   logic         oBORROW;
   logic         oZERO;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   logic         oOVF;
`endif

   int total = 0;
   int bad   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iSTART  (iSTART),
      .iA      (iA),
      .iB      (iB),
      .oBUSY   (oBUSY),
      .oDONE   (oDONE),
      .oDIFF   (oDIFF),
      .oBORROW (oBORROW),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      .oZERO   (oZERO),
      .oOVF    (oOVF)
`else
      .oZERO   (oZERO)
`endif
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      @(negedge iCLK);
   endtask

   // Full operation with latency, busy-length, hold and result checks.
   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expD, input logic expBr,
                        input logic expZ, input logic expOvf);
      int   edges;
      int   busyCnt;
      logic seen;
      logic [W-1:0] prevD;
      prevD  = oDIFF;
      iA     = a;
      iB     = b;
      iSTART = 1'b1;
      tick();
      iSTART  = 1'b0;
      iA      = ~a;
      iB      = ~b;
      edges   = 0;
      busyCnt = 0;
      seen    = 1'b0;
      while (!seen && edges < 20) begin
         if (oBUSY) busyCnt++;
         if (oDONE) begin
            seen = 1'b1;
         end else begin
            if (edges == 4) check("no_partial", oDIFF, prevD);
            tick();
            edges++;
         end
      end
      check("done_seen", seen, 1'b1);
      check("latency", edges, W);
      check("diff", oDIFF, expD);
      check("borrow", oBORROW, expBr);
      check("zero", oZERO, expZ);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      check("ovf", oOVF, expOvf);
`else
      if (expOvf === 1'bx) check("ovf_arg", expOvf, 1'b0);
`endif
      tick();
      if (oBUSY) busyCnt++;
      check("busy_cycles", busyCnt, W + 1);
      check("done_one_cycle", oDONE, 1'b0);
      check("hold_diff", oDIFF, expD);
   endtask

   initial begin
      int doneCnt;
      int edges;
      logic [W-1:0] capD;

      iRST   = 1'b1;
      iSTART = 1'b0;
      iA     = '0;
      iB     = '0;
      tick();
      tick();
      check("rst_busy", oBUSY, 1'b0);
      check("rst_done", oDONE, 1'b0);
      check("rst_diff", oDIFF, 8'h00);
      check("rst_borrow", oBORROW, 1'b0);
      check("rst_zero", oZERO, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      check("rst_ovf", oOVF, 1'b0);
`endif
      iRST = 1'b0;
      tick();

      runOp(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
      runOp(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
      runOp(8'hA7, 8'hA7, 8'h00, 1'b0, 1'b1, 1'b0);
      runOp(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
      runOp(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
      runOp(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
      runOp(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);

      // iSTART during SHIFT is ignored.
      iA = 8'h05; iB = 8'h03; iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      tick();
      tick();
      iA = 8'hFF; iB = 8'h00; iSTART = 1'b1;
      tick();
      iSTART  = 1'b0;
      doneCnt = 0;
      capD    = '0;
      for (int i = 0; i < 20; i++) begin
         if (oDONE) begin
            doneCnt++;
            capD = oDIFF;
         end
         tick();
      end
      check("ign_done_count", doneCnt, 1);
      check("ign_diff", capD, 8'h02);
      check("ign_hold", oDIFF, 8'h02);

      // Reset mid-operation aborts immediately.
      iA = 8'h05; iB = 8'h03; iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      tick();
      tick();
      tick();
      #2 iRST = 1'b1;
      #1;
      check("abort_busy", oBUSY, 1'b0);
      check("abort_done", oDONE, 1'b0);
      check("abort_diff", oDIFF, 8'h00);
      check("abort_borrow", oBORROW, 1'b0);
      tick();
      iRST    = 1'b0;
      doneCnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (oDONE) doneCnt++;
         tick();
      end
      check("abort_no_done", doneCnt, 0);
      runOp(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0);

      // iSTART held high: back-to-back operations every W+2 cycles.
      iA = 8'h20; iB = 8'h10; iSTART = 1'b1;
      edges = 0;
      while (!oDONE && edges < 30) begin
         tick();
         edges++;
      end
      check("b2b_first", oDONE, 1'b1);
      tick();
      edges = 1;
      while (!oDONE && edges < 30) begin
         tick();
         edges++;
      end
      check("b2b_period", edges, W + 2);
      check("b2b_diff", oDIFF, 8'h10);
      iSTART = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("b2b_idle", oBUSY, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
